decode_execute_stage_reg: RTL and testbench

//  Parametrised ID/EX pipeline register between register-file read and ALU stage.

---
 rtl/pipeline_pkg.sv | 27 ++
 rtl/sat_counter.sv | 36 +++
 rtl/decode_execute_stage_reg.sv | 173 +++++++++++++++++
 tb/tb_decode_execute_stage_reg.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/pipeline_pkg.sv
// Shared widths, ALU encodings and the ID/EX control bundle for the pipeline.
package pipeline_pkg;

  localparam int DATA_W     = 32;
  localparam int REG_ADDR_W = 5;
  localparam int ALUCTRL_W  = 3;
  localparam int CNT_W      = 16;

  localparam logic [ALUCTRL_W-1:0] ALU_AND = 3'b000;
  localparam logic [ALUCTRL_W-1:0] ALU_OR  = 3'b001;
  localparam logic [ALUCTRL_W-1:0] ALU_ADD = 3'b010;
  localparam logic [ALUCTRL_W-1:0] ALU_SUB = 3'b110;
  localparam logic [ALUCTRL_W-1:0] ALU_SLT = 3'b111;

  typedef struct packed {
    logic                 RegWrite;
    logic                 MemtoReg;
    logic                 MemWrite;
    logic                 Branch;
    logic [ALUCTRL_W-1:0] ALUControl;
    logic                 ALUSrc;
    logic                 RegDst;
  } id_ex_ctrl_t;

  localparam id_ex_ctrl_t CTRL_BUBBLE = '0;

endpackage

// File: rtl/sat_counter.sv
// Event counter that sticks at all-ones; a clear wins over a same-edge increment.
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] cnt
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Next count: clear, saturating increment, or hold.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Count register with async reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/decode_execute_stage_reg.sv
// ID/EX pipeline register with stall/flush, valid tracking, load-use detection
// against the instruction currently in Decode, and stall/flush event counters.
module decode_execute_stage_reg
  import pipeline_pkg::*;
#(
  parameter int DATA_W     = pipeline_pkg::DATA_W,
  parameter int REG_ADDR_W = pipeline_pkg::REG_ADDR_W,
  parameter int ALUCTRL_W  = pipeline_pkg::ALUCTRL_W,
  parameter int CNT_W      = pipeline_pkg::CNT_W
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  StallE,
  input  logic                  FlushE,
  input  logic                  ClrCnt,
  input  logic                  ValidD,
  input  logic                  RegWriteD,
  input  logic                  MemtoRegD,
  input  logic                  MemWriteD,
  input  logic                  BranchD,
  input  logic                  ALUSrcD,
  input  logic                  RegDstD,
  input  logic [ALUCTRL_W-1:0]  ALUControlD,
  input  logic [DATA_W-1:0]     RD1_D,
  input  logic [DATA_W-1:0]     RD2_D,
  input  logic [REG_ADDR_W-1:0] Rs_D,
  input  logic [REG_ADDR_W-1:0] Rt_D,
  input  logic [REG_ADDR_W-1:0] Rd_D,
  input  logic [DATA_W-1:0]     SignImm_D,
  input  logic [DATA_W-1:0]     PCPlusOne_D,
  output logic                  RegWriteE,
  output logic                  MemtoRegE,
  output logic                  MemWriteE,
  output logic                  BranchE,
  output logic                  ALUSrcE,
  output logic                  RegDstE,
  output logic [ALUCTRL_W-1:0]  ALUControlE,
  output logic [DATA_W-1:0]     SrcA_E,
  output logic [DATA_W-1:0]     RD2_E,
  output logic [DATA_W-1:0]     SignImm_E,
  output logic [DATA_W-1:0]     PCPlusOne_E,
  output logic [REG_ADDR_W-1:0] Rs_E,
  output logic [REG_ADDR_W-1:0] Rt_E,
  output logic [REG_ADDR_W-1:0] Rd_E,
  output logic                  ValidE,
  output logic                  LoadUseStall,
  output logic [CNT_W-1:0]      StallCount,
  output logic [CNT_W-1:0]      FlushCount
);

  id_ex_ctrl_t           ctrl_in;
  id_ex_ctrl_t           ctrl_q,      ctrl_d;
  logic                  valid_q,     valid_d;
  logic [DATA_W-1:0]     srca_q,      srca_d;
  logic [DATA_W-1:0]     rd2_q,       rd2_d;
  logic [DATA_W-1:0]     signimm_q,   signimm_d;
  logic [DATA_W-1:0]     pcplusone_q, pcplusone_d;
  logic [REG_ADDR_W-1:0] rs_q,        rs_d;
  logic [REG_ADDR_W-1:0] rt_q,        rt_d;
  logic [REG_ADDR_W-1:0] rd_q,        rd_d;

  // Pack Decode controls; state-changing bits of a non-instruction are forced off
  // so a stale opcode can never write the register file, memory or redirect fetch.
  always_comb begin
    ctrl_in            = CTRL_BUBBLE;
    ctrl_in.RegWrite   = RegWriteD & ValidD;
    ctrl_in.MemtoReg   = MemtoRegD & ValidD;
    ctrl_in.MemWrite   = MemWriteD & ValidD;
    ctrl_in.Branch     = BranchD   & ValidD;
    ctrl_in.ALUControl = ALUControlD;
    ctrl_in.ALUSrc     = ALUSrcD;
    ctrl_in.RegDst     = RegDstD;
  end

  // Next-state select: flush beats stall beats load.
  always_comb begin
    ctrl_d      = ctrl_q;
    valid_d     = valid_q;
    srca_d      = srca_q;
    rd2_d       = rd2_q;
    signimm_d   = signimm_q;
    pcplusone_d = pcplusone_q;
    rs_d        = rs_q;
    rt_d        = rt_q;
    rd_d        = rd_q;
    if (FlushE) begin
      ctrl_d      = CTRL_BUBBLE;
      valid_d     = 1'b0;
      srca_d      = '0;
      rd2_d       = '0;
      signimm_d   = '0;
      pcplusone_d = '0;
      rs_d        = '0;
      rt_d        = '0;
      rd_d        = '0;
    end else if (!StallE) begin
      ctrl_d      = ctrl_in;
      valid_d     = ValidD;
      srca_d      = RD1_D;
      rd2_d       = RD2_D;
      signimm_d   = SignImm_D;
      pcplusone_d = PCPlusOne_D;
      rs_d        = Rs_D;
      rt_d        = Rt_D;
      rd_d        = Rd_D;
    end
  end

  // E-stage registers with async reset to an empty slot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctrl_q      <= CTRL_BUBBLE;
      valid_q     <= 1'b0;
      srca_q      <= '0;
      rd2_q       <= '0;
      signimm_q   <= '0;
      pcplusone_q <= '0;
      rs_q        <= '0;
      rt_q        <= '0;
      rd_q        <= '0;
    end else begin
      ctrl_q      <= ctrl_d;
      valid_q     <= valid_d;
      srca_q      <= srca_d;
      rd2_q       <= rd2_d;
      signimm_q   <= signimm_d;
      pcplusone_q <= pcplusone_d;
      rs_q        <= rs_d;
      rt_q        <= rt_d;
      rd_q        <= rd_d;
    end
  end

  assign RegWriteE   = ctrl_q.RegWrite;
  assign MemtoRegE   = ctrl_q.MemtoReg;
  assign MemWriteE   = ctrl_q.MemWrite;
  assign BranchE     = ctrl_q.Branch;
  assign ALUSrcE     = ctrl_q.ALUSrc;
  assign RegDstE     = ctrl_q.RegDst;
  assign ALUControlE = ctrl_q.ALUControl;
  assign SrcA_E      = srca_q;
  assign RD2_E       = rd2_q;
  assign SignImm_E   = signimm_q;
  assign PCPlusOne_E = pcplusone_q;
  assign Rs_E        = rs_q;
  assign Rt_E        = rt_q;
  assign Rd_E        = rd_q;
  assign ValidE      = valid_q;

  // Load in E whose destination is a source of the Decode instruction; r0 is
  // hardwired so never hazards. Gated by rst_n so it drops as soon as reset asserts.
  always_comb begin
    LoadUseStall = rst_n & valid_q & ctrl_q.MemtoReg & ctrl_q.RegWrite &
                   (rt_q != '0) & ValidD & ((rt_q == Rs_D) | (rt_q == Rt_D));
  end

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (StallE & ~FlushE),
    .clr   (ClrCnt),
    .cnt   (StallCount)
  );

  sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (FlushE),
    .clr   (ClrCnt),
    .cnt   (FlushCount)
  );

endmodule

// File: tb/tb_decode_execute_stage_reg.sv
// Directed bench for the ID/EX register: reset, load, stall, flush, load-use, counters.
module tb_decode_execute_stage_reg;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int CW = 3;
  localparam int NW = 4;

  logic          clk, rst_n, StallE, FlushE, ClrCnt, ValidD;
  logic          RegWriteD, MemtoRegD, MemWriteD, BranchD, ALUSrcD, RegDstD;
  logic [CW-1:0] ALUControlD;
  logic [DW-1:0] RD1_D, RD2_D, SignImm_D, PCPlusOne_D;
  logic [AW-1:0] Rs_D, Rt_D, Rd_D;
  logic          RegWriteE, MemtoRegE, MemWriteE, BranchE, ALUSrcE, RegDstE;
  logic [CW-1:0] ALUControlE;
  logic [DW-1:0] SrcA_E, RD2_E, SignImm_E, PCPlusOne_E;
  logic [AW-1:0] Rs_E, Rt_E, Rd_E;
  logic          ValidE, LoadUseStall;
  logic [NW-1:0] StallCount, FlushCount;

  int checks   = 0;
  int failures = 0;

  decode_execute_stage_reg #(.DATA_W(DW), .REG_ADDR_W(AW), .ALUCTRL_W(CW), .CNT_W(NW)) dut (
    .clk(clk), .rst_n(rst_n), .StallE(StallE), .FlushE(FlushE), .ClrCnt(ClrCnt),
    .ValidD(ValidD), .RegWriteD(RegWriteD), .MemtoRegD(MemtoRegD), .MemWriteD(MemWriteD),
    .BranchD(BranchD), .ALUSrcD(ALUSrcD), .RegDstD(RegDstD), .ALUControlD(ALUControlD),
    .RD1_D(RD1_D), .RD2_D(RD2_D), .Rs_D(Rs_D), .Rt_D(Rt_D), .Rd_D(Rd_D),
    .SignImm_D(SignImm_D), .PCPlusOne_D(PCPlusOne_D),
    .RegWriteE(RegWriteE), .MemtoRegE(MemtoRegE), .MemWriteE(MemWriteE), .BranchE(BranchE),
    .ALUSrcE(ALUSrcE), .RegDstE(RegDstE), .ALUControlE(ALUControlE),
    .SrcA_E(SrcA_E), .RD2_E(RD2_E), .SignImm_E(SignImm_E), .PCPlusOne_E(PCPlusOne_E),
    .Rs_E(Rs_E), .Rt_E(Rt_E), .Rd_E(Rd_E), .ValidE(ValidE), .LoadUseStall(LoadUseStall),
    .StallCount(StallCount), .FlushCount(FlushCount)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic set_d(input logic [DW-1:0] v, input logic [AW-1:0] a);
    ValidD = v[0]; RegWriteD = v[0]; MemtoRegD = v[0]; MemWriteD = v[0];
    BranchD = v[0]; ALUSrcD = v[0]; RegDstD = v[0]; ALUControlD = v[CW-1:0];
    RD1_D = v; RD2_D = v; SignImm_D = v; PCPlusOne_D = v;
    Rs_D = a; Rt_D = a; Rd_D = a;
  endtask

  initial begin
    rst_n = 1'b0; StallE = 1'b0; FlushE = 1'b0; ClrCnt = 1'b0;
    set_d('0, '0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    chk("rst_srca",   SrcA_E, 0);
    chk("rst_valid",  ValidE, 0);
    chk("rst_cnt",    {StallCount, FlushCount}, 0);

    // Plain load
    ValidD = 1; RegWriteD = 1; RD1_D = 32'hDEADBEEF; RD2_D = 32'h0000_1111;
    Rs_D = 3; Rt_D = 7; Rd_D = 9; SignImm_D = 32'h10; PCPlusOne_D = 32'h100;
    ALUControlD = 3'b010; ALUSrcD = 1;
    step();
    chk("ld_srca",    SrcA_E, 32'hDEADBEEF);
    chk("ld_regwr",   RegWriteE, 1);
    chk("ld_valid",   ValidE, 1);
    chk("ld_rt",      Rt_E, 7);
    chk("ld_aluctl",  ALUControlE, 3'b010);
    chk("ld_pc",      PCPlusOne_E, 32'h100);
    chk("ld_lus",     LoadUseStall, 0);

    // Stall 3 edges while Decode changes
    StallE = 1;
    for (int i = 0; i < 3; i++) begin
      set_d(32'h5000 + i, AW'(i + 1));
      step();
    end
    StallE = 0;
    chk("st_srca",    SrcA_E, 32'hDEADBEEF);
    chk("st_rt",      Rt_E, 7);
    chk("st_rd2",     RD2_E, 32'h0000_1111);
    chk("st_valid",   ValidE, 1);
    chk("st_scnt",    StallCount, 3);
    chk("st_fcnt",    FlushCount, 0);

    // Flush with stall asserted
    StallE = 1; FlushE = 1;
    step();
    StallE = 0; FlushE = 0;
    chk("fl_srca",    SrcA_E, 0);
    chk("fl_regwr",   RegWriteE, 0);
    chk("fl_valid",   ValidE, 0);
    chk("fl_rt",      Rt_E, 0);
    chk("fl_pc",      PCPlusOne_E, 0);
    chk("fl_alusrc",  ALUSrcE, 0);
    chk("fl_fcnt",    FlushCount, 1);
    chk("fl_scnt",    StallCount, 3);

    // Invalid Decode: controls squashed, data still captured
    set_d('1, '1);
    ValidD = 0; RD1_D = 32'h1234;
    step();
    chk("inv_ctrl",   {RegWriteE, MemtoRegE, MemWriteE, BranchE}, 0);
    chk("inv_alusrc", ALUSrcE, 1);
    chk("inv_srca",   SrcA_E, 32'h1234);
    chk("inv_valid",  ValidE, 0);

    // Load-use: lw with Rt=5 into E
    set_d('0, '0);
    ValidD = 1; RegWriteD = 1; MemtoRegD = 1; Rs_D = 1; Rt_D = 5; Rd_D = 8;
    step();
    Rs_D = 5; Rt_D = 2;
    #1 chk("lu_rs",   LoadUseStall, 1);
    Rs_D = 1; Rt_D = 5;
    #1 chk("lu_rt",   LoadUseStall, 1);
    Rs_D = 1; Rt_D = 2;
    #1 chk("lu_none", LoadUseStall, 0);
    Rs_D = 5; ValidD = 0;
    #1 chk("lu_invd", LoadUseStall, 0);
    ValidD = 1; StallE = 1;
    step();
    StallE = 0;
    chk("lu_hold",    LoadUseStall, 1);
    // lw targeting r0
    Rs_D = 1; Rt_D = 0;
    step();
    Rs_D = 0;
    #1 chk("lu_r0",   LoadUseStall, 0);
    // Empty E slot
    FlushE = 1;
    step();
    FlushE = 0;
    Rs_D = 5; Rt_D = 5;
    #1 chk("lu_inve", LoadUseStall, 0);

    // Async reset mid-cycle with all-ones Decode
    set_d('1, '1);
    step();
    chk("ones_rd2",   RD2_E, 32'hFFFF_FFFF);
    chk("ones_lus",   LoadUseStall, 1);
    StallE = 1;
    #2 rst_n = 0;
    #1;
    chk("ar_srca",    SrcA_E, 0);
    chk("ar_rd2",     RD2_E, 0);
    chk("ar_ctrl",    {RegWriteE, MemtoRegE, MemWriteE, BranchE, ALUSrcE, RegDstE, ALUControlE}, 0);
    chk("ar_spec",    {Rs_E, Rt_E, Rd_E}, 0);
    chk("ar_valid",   ValidE, 0);
    chk("ar_lus",     LoadUseStall, 0);
    chk("ar_cnt",     {StallCount, FlushCount}, 0);
    @(negedge clk);
    rst_n = 1;

    // Saturation then clear
    set_d('0, '0);
    StallE = 1;
    repeat (20) step();
    chk("sat_scnt",   StallCount, 15);
    StallE = 0; FlushE = 1;
    step();
    chk("sat_fcnt",   FlushCount, 1);
    chk("sat_shold",  StallCount, 15);
    FlushE = 1; StallE = 1; ClrCnt = 1;
    step();
    ClrCnt = 0; FlushE = 0; StallE = 1;
    chk("clr_scnt",   StallCount, 0);
    chk("clr_fcnt",   FlushCount, 0);
    step();
    StallE = 0;
    chk("post_clr",   StallCount, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    failures++;
    $display("FAIL timeout: got no finish expected finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end

endmodule
